// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage and its long-latency result FIFO.
package wb_stage_pkg;

    localparam int         DW_DEF   = 32;
    localparam logic [4:0] REG_RA   = 5'd31;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         LINK_OFS = 8;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_PIPE,
        WB_LU
    } wb_sel_e;

    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        rd_onehot = 32'd1 << rd;
    endfunction

endpackage

// File: rtl/wb_lu_fifo.sv
// Long-latency result FIFO with per-entry rd visibility; registered state, one-edge push-to-head latency.
// No internal backpressure: caller must not push when full (push with simultaneous pop is not required).
module wb_lu_fifo
    import wb_stage_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        push_i,
    input  logic [4:0]                  push_rd_i,
    input  logic [DW-1:0]               push_dat_i,
    input  logic                        pop_i,
    output logic [4:0]                  head_rd_o,
    output logic [DW-1:0]               head_dat_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic [DEPTH-1:0]            ent_vld_o,
    output logic [DEPTH-1:0][4:0]       ent_rd_o
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]            wp_q, rp_q;
    logic [DEPTH-1:0]       vld_q;
    logic [DEPTH-1:0][4:0]  rd_mem_q;
    logic [DW-1:0]          dat_mem_q [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o    = (wp_q == rp_q);
    assign full_o     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign count_o    = wp_q - rp_q;
    assign head_rd_o  = rd_mem_q[rp_q[AW-1:0]];
    assign head_dat_o = dat_mem_q[rp_q[AW-1:0]];
    assign ent_vld_o  = vld_q;
    assign ent_rd_o   = rd_mem_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wp_q     <= '0;
            rp_q     <= '0;
            vld_q    <= '0;
            rd_mem_q <= '0;
            for (int i = 0; i < DEPTH; i++) dat_mem_q[i] <= '0;
        end else begin
            if (pop_i) begin
                rp_q                 <= rp_q + PTR_ONE;
                vld_q[rp_q[AW-1:0]]  <= 1'b0;
            end
            // Push after pop so a full-FIFO push into the slot being freed keeps its valid bit.
            if (push_i) begin
                wp_q                    <= wp_q + PTR_ONE;
                vld_q[wp_q[AW-1:0]]     <= 1'b1;
                rd_mem_q[wp_q[AW-1:0]]  <= push_rd_i;
                dat_mem_q[wp_q[AW-1:0]] <= push_dat_i;
            end
        end
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB register plus long-latency result merge onto the single regfile write port (optional WB_LINK_EN).
// One edge MEM->write port; stall_req forces an upstream hold and a bubble when the FIFO is full or starved.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DW           = DW_DEF,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          mem_valid,
    input  logic          mem_reg_write,
    input  logic          mem_to_reg,
    input  logic [4:0]    mem_rd,
    input  logic [DW-1:0] mem_alu_result,
    input  logic [DW-1:0] mem_load_data,
    input  logic          mem_link,
    input  logic [DW-1:0] mem_pc,
    input  logic          lu_valid,
    input  logic [4:0]    lu_rd,
    input  logic [DW-1:0] lu_data,
    output logic          lu_ready,
    input  logic          halted,
    output logic          reg_write,
    output logic [4:0]    rd_out,
    output logic [DW-1:0] write_data,
    output logic          stall_req,
    output logic [31:0]   pending_mask,
    output logic          drain_done
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic            valid_q, valid_d;
    logic            wr_q, wr_d;
    logic [4:0]      rd_q, rd_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            drain_q, drain_d;

    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [4:0]              head_rd;
    logic [DW-1:0]           head_dat;
    logic [$clog2(DEPTH):0]  fifo_cnt;
    logic [DEPTH-1:0]        ent_vld;
    logic [DEPTH-1:0][4:0]   ent_rd;
    logic                    pipe_cand;
    wb_sel_e                 sel;

    always_comb begin
        valid_d = mem_valid;
        wr_d    = mem_reg_write;
        rd_d    = mem_rd;
        dat_d   = mem_to_reg ? mem_load_data : mem_alu_result;
`ifdef WB_LINK_EN
        if (mem_link) begin
            wr_d  = 1'b1;
            rd_d  = REG_RA;
            dat_d = mem_pc + DW'(LINK_OFS);
        end
`endif
        if (stall_req) valid_d = 1'b0;
    end

`ifndef WB_LINK_EN
    logic unused_link;
    assign unused_link = ^{mem_link, mem_pc};
`endif
    logic unused_fifo_cnt;
    assign unused_fifo_cnt = ^fifo_cnt;

    assign lu_ready  = ~fifo_full;
    assign fifo_push = lu_valid & lu_ready & (lu_rd != REG_ZERO);
    assign pipe_cand = valid_q & wr_q & (rd_q != REG_ZERO);

    wb_lu_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_b      (rst_b),
        .push_i     (fifo_push),
        .push_rd_i  (lu_rd),
        .push_dat_i (lu_data),
        .pop_i      (fifo_pop),
        .head_rd_o  (head_rd),
        .head_dat_o (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt),
        .ent_vld_o  (ent_vld),
        .ent_rd_o   (ent_rd)
    );

    always_comb begin
        sel        = WB_NONE;
        reg_write  = 1'b0;
        rd_out     = REG_ZERO;
        write_data = '0;
        fifo_pop   = 1'b0;
        if (pipe_cand)        sel = WB_PIPE;
        else if (!fifo_empty) sel = WB_LU;
        unique case (sel)
            WB_PIPE: begin
                reg_write  = 1'b1;
                rd_out     = rd_q;
                write_data = dat_q;
            end
            WB_LU: begin
                reg_write  = 1'b1;
                rd_out     = head_rd;
                write_data = head_dat;
                fifo_pop   = 1'b1;
            end
            default: ;
        endcase
    end

    // Starvation counter saturates at the limit so a held stall cannot wrap it.
    always_comb begin
        cnt_d = cnt_q;
        if (fifo_pop || fifo_empty)
            cnt_d = '0;
        else if (pipe_cand && (cnt_q < CW'(STARVE_LIMIT)))
            cnt_d = cnt_q + CW'(1);
    end

    assign stall_req = fifo_full | (cnt_q >= CW'(STARVE_LIMIT));
    assign drain_d   = halted & fifo_empty & ~valid_q & ~lu_valid;
    assign drain_done = drain_q;

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ent_vld[i]) pending_mask = pending_mask | rd_onehot(ent_rd[i]);
        pending_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= REG_ZERO;
            dat_q   <= '0;
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    a_no_pipe_write_to_pending: assert property (@(posedge clk) disable iff (!rst_b)
        !(pipe_cand && pending_mask[rd_q]));

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, write select, FIFO merge/starvation, full, halt drain, link write.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        mem_valid, mem_reg_write, mem_to_reg, mem_link;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result, mem_load_data, mem_pc;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready, halted, reg_write, stall_req, drain_done;
    logic [4:0]  rd_out;
    logic [31:0] write_data, pending_mask;

    int checks = 0;
    int errors = 0;

    wb_stage dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_to_reg     (mem_to_reg),
        .mem_rd         (mem_rd),
        .mem_alu_result (mem_alu_result),
        .mem_load_data  (mem_load_data),
        .mem_link       (mem_link),
        .mem_pc         (mem_pc),
        .lu_valid       (lu_valid),
        .lu_rd          (lu_rd),
        .lu_data        (lu_data),
        .lu_ready       (lu_ready),
        .halted         (halted),
        .reg_write      (reg_write),
        .rd_out         (rd_out),
        .write_data     (write_data),
        .stall_req      (stall_req),
        .pending_mask   (pending_mask),
        .drain_done     (drain_done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic v, input logic w, input logic tr, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] ld);
        mem_valid      = v;
        mem_reg_write  = w;
        mem_to_reg     = tr;
        mem_rd         = rd;
        mem_alu_result = alu;
        mem_load_data  = ld;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        set_mem(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0);
        mem_link = 1'b0; mem_pc = '0; halted = 1'b0;
        lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
        #12;
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL rst_reg_write: got %b want 0", reg_write); end
        checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL rst_rd_out: got %0d want 0", rd_out); end
        checks++; if (write_data !== 32'h0) begin errors++; $display("FAIL rst_write_data: got %h want 0", write_data); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall_req: got %b want 0", stall_req); end
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL rst_lu_ready: got %b want 1", lu_ready); end
        checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL rst_pending_mask: got %h want 0", pending_mask); end
        checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL rst_drain_done: got %b want 0", drain_done); end
        #1 rst_b = 1'b1;
        cyc();
        checks++; if (reg_write !== 1'b1 || rd_out !== 5'd5 || write_data !== 32'h1234) begin
            errors++; $display("FAIL first_write: got we=%b rd=%0d data=%h want we=1 rd=5 data=1234", reg_write, rd_out, write_data);
        end
    endtask

    task automatic test_rd_zero();
        set_mem(1'b1, 1'b1, 1'b0, 5'd0, 32'hBEEF, 32'h0);
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h55;
        cyc();
        lu_valid = 1'b0;
        checks++; if (reg_write !== 1'b0 || write_data !== 32'h0) begin
            errors++; $display("FAIL rd0_write: got we=%b data=%h want we=0 data=0", reg_write, write_data);
        end
        checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL rd0_mask: got %h want 0", pending_mask); end
        set_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        cyc();
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL rd0_discard: got we=%b want 0", reg_write); end
    endtask

    task automatic test_starve();
        set_mem(1'b1, 1'b1, 1'b0, 5'd1, 32'h101, 32'h0);
        lu_valid = 1'b1; lu_rd = 5'd8; lu_data = 32'hCAFE;
        cyc();
        lu_valid = 1'b0;
        checks++; if (pending_mask !== 32'h100) begin errors++; $display("FAIL starve_mask: got %h want 100", pending_mask); end
        checks++; if (rd_out !== 5'd1 || write_data !== 32'h101 || stall_req !== 1'b0) begin
            errors++; $display("FAIL starve_pipe0: got rd=%0d data=%h stall=%b want rd=1 data=101 stall=0", rd_out, write_data, stall_req);
        end
        for (int i = 1; i <= 4; i++) begin
            set_mem(1'b1, 1'b1, 1'b0, 5'(1 + i), 32'h101 + 32'(i), 32'h0);
            cyc();
            checks++; if (rd_out !== 5'(1 + i) || stall_req !== (i == 4)) begin
                errors++; $display("FAIL starve_wait%0d: got rd=%0d stall=%b want rd=%0d stall=%b", i, rd_out, stall_req, 1 + i, i == 4);
            end
        end
        cyc();
        checks++; if (reg_write !== 1'b1 || rd_out !== 5'd8 || write_data !== 32'hCAFE) begin
            errors++; $display("FAIL starve_drain: got we=%b rd=%0d data=%h want we=1 rd=8 data=cafe", reg_write, rd_out, write_data);
        end
        cyc();
        checks++; if (pending_mask !== 32'h0 || stall_req !== 1'b0 || reg_write !== 1'b0) begin
            errors++; $display("FAIL starve_after: got mask=%h stall=%b we=%b want 0 0 0", pending_mask, stall_req, reg_write);
        end
        cyc();
        checks++; if (rd_out !== 5'd5 || write_data !== 32'h105) begin
            errors++; $display("FAIL starve_resume: got rd=%0d data=%h want rd=5 data=105", rd_out, write_data);
        end
    endtask

    task automatic test_full();
        set_mem(1'b1, 1'b1, 1'b0, 5'd3, 32'h33, 32'h0);
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'hA1;
        cyc();
        lu_rd = 5'd10; lu_data = 32'hA2;
        cyc();
        lu_valid = 1'b0;
        checks++; if (lu_ready !== 1'b0 || stall_req !== 1'b1) begin
            errors++; $display("FAIL full_flags: got lu_ready=%b stall=%b want 0 1", lu_ready, stall_req);
        end
        checks++; if (pending_mask !== 32'h600 || rd_out !== 5'd3) begin
            errors++; $display("FAIL full_mask: got mask=%h rd=%0d want 600 rd=3", pending_mask, rd_out);
        end
        cyc();
        checks++; if (rd_out !== 5'd9 || write_data !== 32'hA1 || stall_req !== 1'b1) begin
            errors++; $display("FAIL full_pop1: got rd=%0d data=%h stall=%b want 9 a1 1", rd_out, write_data, stall_req);
        end
        cyc();
        checks++; if (rd_out !== 5'd10 || write_data !== 32'hA2 || stall_req !== 1'b0 || lu_ready !== 1'b1) begin
            errors++; $display("FAIL full_pop2: got rd=%0d data=%h stall=%b rdy=%b want 10 a2 0 1", rd_out, write_data, stall_req, lu_ready);
        end
        cyc();
        checks++; if (rd_out !== 5'd3 || pending_mask !== 32'h0) begin
            errors++; $display("FAIL full_resume: got rd=%0d mask=%h want 3 0", rd_out, pending_mask);
        end
    endtask

    task automatic test_halt_drain();
        halted = 1'b1;
        set_mem(1'b1, 1'b1, 1'b0, 5'd4, 32'h44, 32'h0);
        lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'hC12;
        cyc();
        lu_valid = 1'b0;
        set_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        checks++; if (rd_out !== 5'd4 || write_data !== 32'h44 || drain_done !== 1'b0) begin
            errors++; $display("FAIL halt_stage: got rd=%0d data=%h done=%b want 4 44 0", rd_out, write_data, drain_done);
        end
        cyc();
        checks++; if (rd_out !== 5'd12 || write_data !== 32'hC12 || drain_done !== 1'b0) begin
            errors++; $display("FAIL halt_fifo: got rd=%0d data=%h done=%b want 12 c12 0", rd_out, write_data, drain_done);
        end
        cyc();
        checks++; if (reg_write !== 1'b0 || drain_done !== 1'b0) begin
            errors++; $display("FAIL halt_idle: got we=%b done=%b want 0 0", reg_write, drain_done);
        end
        cyc();
        checks++; if (drain_done !== 1'b1) begin errors++; $display("FAIL halt_done: got %b want 1", drain_done); end
        // Reset mid-drain: one FIFO entry and a valid stage, then async reset between edges.
        set_mem(1'b1, 1'b1, 1'b0, 5'd6, 32'h66, 32'h0);
        lu_valid = 1'b1; lu_rd = 5'd13; lu_data = 32'hD13;
        cyc();
        lu_valid = 1'b0;
        set_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        #2 rst_b = 1'b0;
        #1;
        checks++; if (reg_write !== 1'b0 || rd_out !== 5'd0 || write_data !== 32'h0 || pending_mask !== 32'h0) begin
            errors++; $display("FAIL arst_port: got we=%b rd=%0d data=%h mask=%h want all 0", reg_write, rd_out, write_data, pending_mask);
        end
        checks++; if (lu_ready !== 1'b1 || stall_req !== 1'b0 || drain_done !== 1'b0) begin
            errors++; $display("FAIL arst_flags: got rdy=%b stall=%b done=%b want 1 0 0", lu_ready, stall_req, drain_done);
        end
        halted = 1'b0;
        #1 rst_b = 1'b1;
        cyc();
        checks++; if (reg_write !== 1'b0 || pending_mask !== 32'h0) begin
            errors++; $display("FAIL arst_discard: got we=%b mask=%h want 0 0", reg_write, pending_mask);
        end
    endtask

    task automatic test_link();
        logic [4:0]  exp_rd;
        logic [31:0] exp_dat;
`ifdef WB_LINK_EN
        exp_rd = 5'd31; exp_dat = 32'h408;
`else
        exp_rd = 5'd7;  exp_dat = 32'h88;
`endif
        set_mem(1'b1, 1'b1, 1'b1, 5'd7, 32'h77, 32'h88);
        mem_link = 1'b1; mem_pc = 32'h400;
        cyc();
        mem_link = 1'b0;
        set_mem(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        checks++; if (reg_write !== 1'b1 || rd_out !== exp_rd || write_data !== exp_dat) begin
            errors++; $display("FAIL link_write: got we=%b rd=%0d data=%h want 1 %0d %h", reg_write, rd_out, write_data, exp_rd, exp_dat);
        end
    endtask

    initial begin
        test_reset();
        test_rd_zero();
        test_starve();
        test_full();
        test_halt_drain();
        test_link();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
